// File: rtl/button_link_pkg.sv
// Shared types and constants for the host-link button frame decoder.
// A frame is SYNC, P0, P1, P2, CHK with CHK = P0 ^ P1 ^ P2.
package button_link_pkg;

   localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hB5;
   localparam int unsigned FRAME_LEN         = 5;
   localparam int unsigned BUTTON_W          = 24;

   typedef enum logic [2:0] {
      HUNT    = 3'd0,
      GET_P0  = 3'd1,
      GET_P1  = 3'd2,
      GET_P2  = 3'd3,
      GET_CHK = 3'd4
   } link_state_e;

   // Field order makes the struct bit-identical to the {P2,P1,P0} button vector.
   typedef struct packed {
      logic [7:0] p2;
      logic [7:0] p1;
      logic [7:0] p0;
   } button_payload_t;

   function automatic logic [7:0] payload_chk(input button_payload_t p);
      return p.p0 ^ p.p1 ^ p.p2;
   endfunction

endpackage

// File: rtl/link_timeout_counter.sv
// Saturating idle counter: expired is high in the LIMIT-th consecutive enabled
// cycle after a restart and stays high until restarted. LIMIT = 0 disables it.
module link_timeout_counter #(
   parameter int unsigned LIMIT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW     = (LIMIT < 2) ? 1 : $clog2(LIMIT);
   localparam int unsigned TERM_I = (LIMIT == 32'd0) ? 32'd0 : LIMIT - 32'd1;
   localparam logic [CW-1:0] TERM = CW'(TERM_I);
   localparam bit ACTIVE          = (LIMIT != 32'd0);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic          expired_next;

   // Flag is raised one count early so the consumer acts on the LIMIT-th cycle edge.
   always_comb begin
      cnt_next     = cnt;
      expired_next = 1'b0;
      if (restart) begin
         cnt_next = '0;
      end else if (enable && (cnt != TERM)) begin
         cnt_next = cnt + CW'(1);
      end
      if (ACTIVE && enable) begin
         expired_next = (cnt_next == TERM);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         expired <= 1'b0;
      end else begin
         cnt     <= cnt_next;
         expired <= expired_next;
      end
   end

endmodule

// File: rtl/button_frame_decoder.sv
// Decodes 5-byte button frames from the host link into a held 24-bit button
// vector, with inter-byte timeout and a hold watchdog that releases stale buttons.
module button_frame_decoder
   import button_link_pkg::*;
#(
   parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
   parameter int unsigned BYTE_TIMEOUT = 1_200_000,
   parameter int unsigned HOLD_TIMEOUT = 12_000_000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          rx_data,
   input  logic                rx_valid,
   output logic                rx_ready,
   output logic [BUTTON_W-1:0] buttons,
   output logic                frame_ok,
   output logic                frame_err
);

   link_state_e     state;
   button_payload_t payload;

   logic accept_c;
   logic chk_match_c;
   logic good_frame_c;
   logic byte_enable_c;
   logic byte_timeout_c;
   logic byte_restart_c;
   logic byte_expired;
   logic hold_expired;

   assign accept_c       = rx_valid & rx_ready;
   assign chk_match_c    = (rx_data == payload_chk(payload));
   assign good_frame_c   = accept_c & (state == GET_CHK) & chk_match_c;
   assign byte_enable_c  = (state != HUNT);
   // An accepted byte in the expiry cycle beats the timeout.
   assign byte_timeout_c = byte_expired & byte_enable_c & ~accept_c;
   assign byte_restart_c = accept_c | ~byte_enable_c | byte_timeout_c;

   link_timeout_counter #(
      .LIMIT(BYTE_TIMEOUT)
   ) u_byte_timeout (
      .clk    (clk),
      .rst    (rst),
      .restart(byte_restart_c),
      .enable (byte_enable_c),
      .expired(byte_expired)
   );

   link_timeout_counter #(
      .LIMIT(HOLD_TIMEOUT)
   ) u_hold_watchdog (
      .clk    (clk),
      .rst    (rst),
      .restart(good_frame_c),
      .enable (1'b1),
      .expired(hold_expired)
   );

   // Frame FSM; a good frame later in this block overrides the watchdog clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= HUNT;
         payload   <= '0;
         buttons   <= '0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         rx_ready  <= 1'b0;
      end else begin
         rx_ready  <= 1'b1;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         if (hold_expired) begin
            buttons <= '0;
         end
         if (accept_c) begin
            case (state)
               HUNT: begin
                  if (rx_data == SYNC_BYTE) begin
                     state   <= GET_P0;
                     payload <= '0;
                  end
               end
               GET_P0: begin
                  payload.p0 <= rx_data;
                  state      <= GET_P1;
               end
               GET_P1: begin
                  payload.p1 <= rx_data;
                  state      <= GET_P2;
               end
               GET_P2: begin
                  payload.p2 <= rx_data;
                  state      <= GET_CHK;
               end
               GET_CHK: begin
                  state <= HUNT;
                  if (chk_match_c) begin
                     buttons  <= payload;
                     frame_ok <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
               default: begin
                  state <= HUNT;
               end
            endcase
         end else if (byte_timeout_c) begin
            state     <= HUNT;
            payload   <= '0;
            frame_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_button_frame_decoder.sv
// Self-checking bench for button_frame_decoder: frame table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_button_frame_decoder;
   import button_link_pkg::*;

   localparam int unsigned BYTE_TO = 20;
   localparam int unsigned HOLD    = 100;
   localparam logic [7:0]  SYNC    = 8'hB5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [23:0] buttons;
   logic        frame_ok;
   logic        frame_err;

   button_frame_decoder #(
      .SYNC_BYTE   (SYNC),
      .BYTE_TIMEOUT(BYTE_TO),
      .HOLD_TIMEOUT(HOLD)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .buttons  (buttons),
      .frame_ok (frame_ok),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int n_tests  = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int ok_seen  = 0;
   int err_seen = 0;

   // Reference model state: bytes of the frame in progress, idle and hold ages.
   logic [7:0]  fq[$];
   int          idle = 0;
   int          age  = 0;
   logic [23:0] m_buttons = '0;
   logic        m_ok = 1'b0;
   logic        m_err = 1'b0;
   logic        m_ready = 1'b0;

   typedef struct {
      logic [55:0] bytes;
      int          n;
      logic [23:0] exp_buttons;
      int          exp_ok;
      int          exp_err;
   } vec_t;

   vec_t vt[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_step();
      logic        acc;
      logic        good;
      logic [23:0] nb;
      good = 1'b0;
      nb   = '0;
      if (rst) begin
         fq.delete();
         idle      = 0;
         age       = 0;
         m_buttons = '0;
         m_ok      = 1'b0;
         m_err     = 1'b0;
         m_ready   = 1'b0;
      end else begin
         acc     = rx_valid && m_ready;
         m_ready = 1'b1;
         m_ok    = 1'b0;
         m_err   = 1'b0;
         if (acc) begin
            idle = 0;
            if (fq.size() == 0) begin
               if (rx_data == SYNC) fq.push_back(rx_data);
            end else begin
               fq.push_back(rx_data);
               if (fq.size() == FRAME_LEN) begin
                  if ((fq[1] ^ fq[2] ^ fq[3]) == fq[4]) begin
                     good = 1'b1;
                     nb   = {fq[3], fq[2], fq[1]};
                  end else begin
                     m_err = 1'b1;
                  end
                  fq.delete();
               end
            end
         end else if (fq.size() != 0) begin
            idle++;
            if (idle >= int'(BYTE_TO)) begin
               m_err = 1'b1;
               fq.delete();
               idle = 0;
            end
         end
         if (good) begin
            m_buttons = nb;
            m_ok      = 1'b1;
            age       = 0;
         end else begin
            if (age < int'(HOLD)) age++;
            if (HOLD != 0 && age == int'(HOLD)) m_buttons = '0;
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      cyc++;
      check("rx_ready", 32'(rx_ready), 32'(m_ready));
      check("buttons", 32'(buttons), 32'(m_buttons));
      check("frame_ok", 32'(frame_ok), 32'(m_ok));
      check("frame_err", 32'(frame_err), 32'(m_err));
      if (frame_ok) ok_seen++;
      if (frame_err) err_seen++;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      cycle();
      rx_valid = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      rx_valid = 1'b0;
      repeat (n) begin
         rx_data = 8'($urandom);
         cycle();
      end
   endtask

   task automatic send_frame(input logic [23:0] v);
      send_byte(SYNC);
      send_byte(v[7:0]);
      send_byte(v[15:8]);
      send_byte(v[23:16]);
      send_byte(v[7:0] ^ v[15:8] ^ v[23:16]);
   endtask

   initial begin
      logic [55:0] bb;
      int          n;
      logic [7:0]  p0, p1, p2, chk;

      vt[0] = '{56'hB5_01_00_80_81_00_00, 5, 24'h800001, 1, 0};
      vt[1] = '{56'hB5_01_00_80_00_00_00, 5, 24'h800001, 0, 1};
      vt[2] = '{56'h33_B5_B5_02_00_B7_00, 6, 24'h0002B5, 1, 0};
      vt[3] = '{56'hB5_12_34_56_70_00_00, 5, 24'h563412, 1, 0};
      vt[4] = '{56'hB5_B5_B5_B5_B5_00_00, 5, 24'hB5B5B5, 1, 0};
      vt[5] = '{56'h00_11_B5_FF_FF_FF_FF, 7, 24'hFFFFFF, 1, 0};

      // Reset state
      rst = 1'b1;
      idle_cycles(3);
      check("reset_buttons", 32'(buttons), 32'h0);
      check("reset_ready", 32'(rx_ready), 32'h0);
      check("reset_ok", 32'(frame_ok), 32'h0);
      check("reset_err", 32'(frame_err), 32'h0);
      rst = 1'b0;
      idle_cycles(1);

      // Frame table
      for (int i = 0; i < 6; i++) begin
         ok_seen  = 0;
         err_seen = 0;
         bb       = vt[i].bytes;
         for (int k = 0; k < vt[i].n; k++) send_byte(bb[55-8*k -: 8]);
         idle_cycles(2);
         check($sformatf("vec%0d_buttons", i), 32'(buttons), 32'(vt[i].exp_buttons));
         check($sformatf("vec%0d_ok", i), 32'(ok_seen), 32'(vt[i].exp_ok));
         check($sformatf("vec%0d_err", i), 32'(err_seen), 32'(vt[i].exp_err));
      end

      // Inter-byte timeout fires in the cycle after BYTE_TO idle cycles
      ok_seen  = 0;
      err_seen = 0;
      send_byte(SYNC);
      send_byte(8'h01);
      idle_cycles(int'(BYTE_TO) - 1);
      check("timeout_early", 32'(err_seen), 32'h0);
      idle_cycles(1);
      check("timeout_pulse", 32'(frame_err), 32'h1);
      send_frame(24'h654321);
      idle_cycles(1);
      check("timeout_recover_buttons", 32'(buttons), 32'h654321);
      check("timeout_recover_ok", 32'(ok_seen), 32'h1);
      check("timeout_err_count", 32'(err_seen), 32'h1);

      // Byte arriving in the expiry cycle wins over the timeout
      ok_seen  = 0;
      err_seen = 0;
      send_byte(SYNC);
      send_byte(8'h01);
      idle_cycles(int'(BYTE_TO) - 1);
      send_byte(8'h00);
      send_byte(8'h80);
      send_byte(8'h81);
      idle_cycles(1);
      check("coincide_err", 32'(err_seen), 32'h0);
      check("coincide_ok", 32'(ok_seen), 32'h1);
      check("coincide_buttons", 32'(buttons), 32'h800001);

      // Hold watchdog releases buttons exactly HOLD cycles after frame_ok
      send_frame(24'hFFFFFF);
      check("hold_frame_ok", 32'(frame_ok), 32'h1);
      n = 0;
      for (int k = 1; k <= 300; k++) begin
         idle_cycles(1);
         if (buttons == 24'h0) begin
            n = k;
            break;
         end
      end
      check("hold_release_cycle", 32'(n), 32'(HOLD));

      // Good frame completing on the watchdog expiry edge wins
      send_frame(24'h332211);
      idle_cycles(int'(HOLD) - 5);
      send_frame(24'h665544);
      check("hold_tie_buttons", 32'(buttons), 32'h665544);
      idle_cycles(1);
      check("hold_tie_after", 32'(buttons), 32'h665544);

      // Reset mid-frame drops the partial frame
      ok_seen  = 0;
      err_seen = 0;
      send_byte(SYNC);
      send_byte(8'h01);
      rst = 1'b1;
      idle_cycles(1);
      check("midrst_buttons", 32'(buttons), 32'h0);
      idle_cycles(1);
      rst = 1'b0;
      idle_cycles(1);
      send_frame(24'h0C0B0A);
      idle_cycles(1);
      check("midrst_new_buttons", 32'(buttons), 32'h0C0B0A);
      check("midrst_err", 32'(err_seen), 32'h0);
      check("midrst_ok", 32'(ok_seen), 32'h1);

      // Randomized traffic against the model
      for (int it = 0; it < 150; it++) begin
         int r;
         r = int'($urandom_range(0, 19));
         if (r < 12) begin
            p0  = 8'($urandom);
            p1  = 8'($urandom);
            p2  = 8'($urandom);
            chk = p0 ^ p1 ^ p2;
            if ($urandom_range(0, 4) == 0) chk = chk ^ 8'($urandom_range(1, 255));
            bb = {SYNC, p0, p1, p2, chk, 16'h0};
            for (int k = 0; k < 5; k++) begin
               if ($urandom_range(0, 12) == 0) idle_cycles(int'($urandom_range(BYTE_TO - 2, BYTE_TO + 3)));
               else idle_cycles(int'($urandom_range(0, 2)));
               send_byte(bb[55-8*k -: 8]);
            end
         end else if (r < 16) begin
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
               rx_valid = 1'($urandom);
               rx_data  = ($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom);
               cycle();
            end
            rx_valid = 1'b0;
         end else if (r < 19) begin
            idle_cycles(int'($urandom_range(30, 130)));
         end else begin
            rst = 1'b1;
            idle_cycles(int'($urandom_range(1, 3)));
            rst = 1'b0;
         end
      end
      idle_cycles(int'(BYTE_TO) + 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/button_frame_decoder.md
BUTTON_FRAME_DECODER -- requirements
Module: button_frame_decoder

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hB5, is the frame start marker.
REQ-002 Parameter BYTE_TIMEOUT, default 1_200_000, is the max idle cycles between bytes within one frame.
REQ-003 Parameter HOLD_TIMEOUT, default 12_000_000, is the cycles without a good frame before buttons are released; 0 disables it.
REQ-004 Port clk, input, 1, is the single clock; all logic SHALL be on its rising edge.
REQ-005 Port rst, input, 1, is the reset: synchronous and active-high.
REQ-006 Port rx_data, input, 8, is the byte from the host link.
REQ-007 Port rx_valid, input, 1, means rx_data is valid this cycle.
REQ-008 Port rx_ready, output, 1, means the decoder accepts a byte this cycle.
REQ-009 Port buttons, output, 24, is the virtual button vector driven to the controllers.
REQ-010 Port frame_ok, output, 1, is a 1-cycle pulse on an accepted frame.
REQ-011 Port frame_err, output, 1, is a 1-cycle pulse on a checksum failure or inter-byte timeout.

Function
REQ-012 A byte SHALL be accepted only in a cycle where rx_valid and rx_ready are both 1.
REQ-013 rx_ready SHALL be 1 in every cycle except reset cycles.
REQ-014 Frame format: SYNC_BYTE, P0, P1, P2, CHK, where CHK = P0^P1^P2.
REQ-015 FSM states: HUNT, GET_P0, GET_P1, GET_P2, GET_CHK.
REQ-016 From HUNT, an accepted byte equal to SYNC_BYTE SHALL move to GET_P0; any other byte SHALL be discarded silently with no frame_err.
REQ-017 Each accepted payload byte SHALL advance GET_P0 -> GET_P1 -> GET_P2 -> GET_CHK; a payload byte equal to SYNC_BYTE SHALL be treated as data.
REQ-018 In GET_CHK, an accepted byte SHALL return the FSM to HUNT.
REQ-019 On a CHK match, the next cycle SHALL have buttons = {P2,P1,P0} and frame_ok = 1.
REQ-020 On a CHK mismatch, the next cycle SHALL have frame_err = 1, and buttons SHALL be unchanged.
REQ-021 Latency from CHK acceptance to the buttons update SHALL be exactly 1 cycle.
REQ-022 Outside HUNT, if BYTE_TIMEOUT cycles pass with no accepted byte, frame_err SHALL pulse, the FSM SHALL go to HUNT, and the partial payload SHALL be discarded.
REQ-023 The inter-byte counter SHALL restart on every accepted byte and SHALL be held at 0 in HUNT.
REQ-024 The hold watchdog SHALL restart on every good frame.
REQ-025 When the hold watchdog reaches HOLD_TIMEOUT, buttons SHALL clear to 0 with no pulse, and the watchdog SHALL then stay expired until the next good frame.
REQ-026 If a good frame completes in the same cycle the hold watchdog expires, the frame SHALL win: buttons take the new value and the watchdog restarts.
REQ-027 If the inter-byte timeout and a byte acceptance coincide, the byte SHALL win and there SHALL be no frame_err.
REQ-028 frame_ok and frame_err SHALL never be 1 in the same cycle.
REQ-029 Both counters SHALL saturate and never wrap.

Reset
REQ-030 Reset values: buttons = 0, frame_ok = 0, frame_err = 0, rx_ready = 0, FSM = HUNT, both counters = 0.
REQ-031 Reset mid-frame SHALL drop the partial frame; decoding SHALL resume at HUNT on the first cycle after rst deasserts.

Structure
REQ-032 The shared package button_link_pkg SHALL hold the SYNC_BYTE default, the FSM state type and FRAME_LEN = 5.
REQ-033 Both timeouts SHALL use one sub-module, link_timeout_counter, instantiated twice.
REQ-034 link_timeout_counter ports: clk, rst, restart, enable, expired; it SHALL be parameterised by LIMIT.

Verification
REQ-035 Send B5,01,00,80,81 -> the cycle after the CHK byte, buttons = 24'h800001 and frame_ok pulses once.
REQ-036 Send B5,01,00,80,00 -> frame_err pulses once and buttons keep their prior value.
REQ-037 Send 33,B5,B5,02,00,B7 (payload byte B5 treated as data) -> the leading 33 is discarded, buttons = 24'h0002B5, frame_ok pulses once.
REQ-038 Send B5,01, then idle BYTE_TIMEOUT cycles -> frame_err pulses and the FSM is in HUNT; a following good frame is accepted.
REQ-039 With HOLD_TIMEOUT = 100, send a good frame 24'hFFFFFF, then idle -> buttons = 0 exactly 100 cycles after the frame_ok pulse.
REQ-040 Assert rst after B5,01 and release it, then send a full good frame -> buttons are 0 during reset and take the new frame value afterwards, with no frame_err.
